da_engine: RTL and testbench

Bit-serial distributed-arithmetic (DA) engine that responds to the FIR controller's `start_DA`/`reset_DA` commands. It consumes one parallel tap vector from the FIFO per sample and walks the sample bits LSB-first through a partial-sum LUT, shifting and accumulating as it goes. It returns one filtered output with a single-cycle `valid_out` pulse. It sits between the tap FIFO and the filter output register, as the responder to the control FSM.

---
 rtl/da_pkg.sv | 20 ++
 rtl/da_lut.sv | 30 +++
 rtl/da_engine.sv | 154 +++++++++++++++
 tb/tb_da_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared types and sizing helpers for the distributed-arithmetic FIR engine.
// Optional LUT pipeline register is enabled with DA_LUT_REG_EN (see da_engine).
package da_pkg;

  localparam int DEF_TAPS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LREG  = 2'd2
  } da_state_t;

  // Sum of TAPS products of DATA_W x COEF_W signed values, plus one guard bit.
  function automatic int acc_width(input int taps, input int data_w, input int coef_w);
    return data_w + coef_w + $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/da_lut.sv
// Combinational partial-sum table: sums the coefficients of the taps whose
// address bit is set, sign-extended to the accumulator width.
module da_lut
  import da_pkg::*;
#(
  parameter int TAPS   = DEF_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = acc_width(DEF_TAPS, DEF_DATA_W, DEF_COEF_W)
) (
  input  logic [TAPS-1:0]        addr,
  input  logic [TAPS*COEF_W-1:0] coef,
  output logic [ACC_W-1:0]       psum
);

  logic [ACC_W-1:0] term [TAPS];

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_term
    logic [COEF_W-1:0] c;
    assign c = coef[gi*COEF_W +: COEF_W];
    assign term[gi] = addr[gi] ? {{(ACC_W-COEF_W){c[COEF_W-1]}}, c} : '0;
  end

  always_comb begin
    psum = '0;
    for (int k = 0; k < TAPS; k++) begin
      psum = psum + term[k];
    end
  end

endmodule

// File: rtl/da_engine.sv
// Bit-serial distributed-arithmetic FIR engine: one tap vector per sample,
// bits walked LSB-first, sign bit subtracted. Define DA_LUT_REG_EN to
// register the LUT output (adds one LREG cycle of latency, same results).
module da_engine
  import da_pkg::*;
#(
  parameter int TAPS   = DEF_TAPS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = acc_width(TAPS, DATA_W, COEF_W)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start_DA,
  input  logic                   reset_DA,
  input  logic                   valid_in,
  input  logic [TAPS*DATA_W-1:0] x_taps,
  input  logic [TAPS*COEF_W-1:0] coef,
  output logic                   ready,
  output logic                   busy,
  output logic [ACC_W-1:0]       y,
  output logic                   valid_out
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef DA_LUT_REG_EN
  localparam da_state_t RUN_STATE = LREG;
`else
  localparam da_state_t RUN_STATE = SHIFT;
`endif

  da_state_t               state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0]        y_reg;
  logic                    valid_out_reg;
  logic                    busy_reg;

  logic [TAPS-1:0]         lut_addr;
  logic [ACC_W-1:0]        lut_out;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] addend_shift;
  logic signed [ACC_W-1:0] acc_next;
  logic                    accept;
  logic                    last_bit;
  logic                    shift_sr;

  assign ready    = (state_reg == IDLE) && start_DA && !reset_DA;
  assign accept   = ready && valid_in;
  assign last_bit = (cnt_reg == CNT_W'(DATA_W - 1));
  assign shift_sr = !reset_DA && (state_reg != IDLE);

  // Per-tap shift registers; bit 0 of each always holds the bit being processed.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    logic [DATA_W-1:0] sr_reg;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sr_reg <= '0;
      end else if (accept) begin
        sr_reg <= x_taps[gi*DATA_W +: DATA_W];
      end else if (shift_sr) begin
        sr_reg <= sr_reg >> 1;
      end
    end

    assign lut_addr[gi] = sr_reg[0];
  end

  da_lut #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_lut (
    .addr (lut_addr),
    .coef (coef),
    .psum (lut_out)
  );

`ifdef DA_LUT_REG_EN
  // The accumulate stage lags the address by one cycle; LREG primes this register.
  logic [ACC_W-1:0] lut_q_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lut_q_reg <= '0;
    end else begin
      lut_q_reg <= lut_out;
    end
  end

  assign addend = $signed(lut_q_reg);
`else
  assign addend = $signed(lut_out);
`endif

  // The sign bit of a two's-complement sample carries negative weight.
  assign addend_shift = addend <<< cnt_reg;
  assign acc_next     = last_bit ? (acc_reg - addend_shift) : (acc_reg + addend_shift);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      y_reg         <= '0;
      valid_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (reset_DA) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      valid_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      valid_out_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= RUN_STATE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        LREG: begin
          state_reg <= SHIFT;
        end
        SHIFT: begin
          acc_reg <= acc_next;
          if (last_bit) begin
            y_reg         <= acc_next;
            valid_out_reg <= 1'b1;
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            cnt_reg       <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign y         = y_reg;
  assign valid_out = valid_out_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_da_engine.sv
// Scoreboard bench for da_engine: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them on every valid_out.
module tb_da_engine;

  localparam int ACC_W = 19;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start_DA = 1'b0;
  logic             reset_DA = 1'b0;
  logic             valid_in = 1'b0;
  logic [31:0]      x_taps = '0;
  logic [31:0]      coef = '0;
  logic             ready;
  logic             busy;
  logic [ACC_W-1:0] y;
  logic             valid_out;

  int n_vec = 0;
  int n_bad = 0;
  int n_results = 0;
  int cyc = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  da_engine dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_DA  (start_DA),
    .reset_DA  (reset_DA),
    .valid_in  (valid_in),
    .x_taps    (x_taps),
    .coef      (coef),
    .ready     (ready),
    .busy      (busy),
    .y         (y),
    .valid_out (valid_out)
  );

  function automatic int sy();
    return int'($signed(y));
  endfunction

  function automatic logic [31:0] pk(input int t0, input int t1, input int t2, input int t3);
    logic [7:0] b0, b1, b2, b3;
    b0 = t0[7:0];
    b1 = t1[7:0];
    b2 = t2[7:0];
    b3 = t3[7:0];
    return {b3, b2, b1, b0};
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every valid_out must match the oldest pending expectation.
  always @(negedge clk) begin
    if (resetn && valid_out) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid_out: got y=%0d, want no result (t=%0t)", sy(), $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        n_results++;
        check("y", sy(), e);
      end
    end
  end

  // Waits (bounded) for the cycle in which the sample is accepted; returns #1 after that edge.
  task automatic wait_accept(input int e, input bit push);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready && valid_in) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept in 40 cycles, want accept");
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] c, input int e);
    x_taps   = x;
    coef     = c;
    valid_in = 1'b1;
    wait_accept(e, 1'b1);
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, rlow, hi_r, hi_b, t0, t1, t2;

    repeat (2) @(posedge clk);
    #1;
    check("reset_y", sy(), 0);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(ready), 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Sum of coefficients, with latency and ready-low window measured
    start_DA = 1'b1;
    coef     = pk(1, 2, 3, 4);
    x_taps   = pk(1, 1, 1, 1);
    valid_in = 1'b1;
    wait_accept(10, 1'b1);
    valid_in = 1'b0;
    n = 0;
    rlow = 0;
    @(negedge clk);
    check("busy_in_shift", int'(busy), 1);
    if (!ready) rlow++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_out) begin
        n = i;
        break;
      end
      if (!ready) rlow++;
    end
    check("latency", n, 8);
    check("ready_low_cycles", rlow, 8);
    check("ready_with_valid_out", int'(ready), 1);
    repeat (3) @(posedge clk);
    #1;

    run(pk(-1, 0, 0, 0), pk(5, 0, 0, 0), -5);
    run(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 65536);
    run(pk(127, 127, 127, 127), pk(-128, -128, -128, -128), -65024);

    // Abort mid-SHIFT: no result, y held, ready back next cycle
    coef     = pk(1, 2, 3, 4);
    x_taps   = pk(5, 5, 5, 5);
    valid_in = 1'b1;
    wait_accept(0, 1'b0);
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_DA = 1'b1;
    @(posedge clk);
    #1;
    reset_DA = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(ready), 1);
    check("abort_busy", int'(busy), 0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_y_held", sy(), -65024);

    // reset_DA in the accept cycle wins
    x_taps   = pk(9, 9, 9, 9);
    valid_in = 1'b1;
    reset_DA = 1'b1;
    @(negedge clk);
    check("reset_vs_accept_ready", int'(ready), 0);
    @(posedge clk);
    #1;
    reset_DA = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check("reset_vs_accept_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    run(pk(2, 2, 2, 2), pk(1, 2, 3, 4), 20);

    // Back-to-back with valid_in held high
    coef     = pk(1, 2, 3, 4);
    x_taps   = pk(1, 2, 3, 4);
    valid_in = 1'b1;
    wait_accept(30, 1'b1);
    t0 = cyc;
    x_taps = pk(-1, -2, -3, -4);
    wait_accept(-30, 1'b1);
    t1 = cyc;
    x_taps = pk(10, 0, -5, 7);
    wait_accept(23, 1'b1);
    t2 = cyc;
    valid_in = 1'b0;
    check("b2b_spacing_1", t1 - t0, 9);
    check("b2b_spacing_2", t2 - t1, 9);
    repeat (12) @(posedge clk);
    #1;

    // start_DA low: valid_in ignored
    start_DA = 1'b0;
    x_taps   = pk(3, 3, 3, 3);
    valid_in = 1'b1;
    hi_r = 0;
    hi_b = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ready) hi_r++;
      if (busy) hi_b++;
    end
    check("nostart_ready_high_cycles", hi_r, 0);
    check("nostart_busy_high_cycles", hi_b, 0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    start_DA = 1'b1;

    // Asynchronous reset mid-SHIFT
    coef     = pk(1, 2, 3, 4);
    x_taps   = pk(1, 1, 1, 1);
    valid_in = 1'b1;
    wait_accept(0, 1'b0);
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_areset_busy", int'(busy), 1);
    check("pre_areset_y", sy(), 23);
    #2;
    resetn = 1'b0;
    #1;
    check("areset_y", sy(), 0);
    check("areset_busy", int'(busy), 0);
    check("areset_valid_out", int'(valid_out), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    check("pending_expectations", exp_q.size(), 0);
    check("result_count", n_results, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, want finish");
    $fatal(1, "timeout");
  end

endmodule
